// File: rtl/basys3_pkg.sv
// Shared constants for the Basys3 full-adder tutorial block: switch/LED bit
// positions, default pipeline parameters and the debounce counter sizing rule.
package basys3_pkg;

   localparam int SW_A     = 0;
   localparam int SW_B     = 1;
   localparam int SW_CIN   = 2;
   localparam int LED_SUM  = 0;
   localparam int LED_COUT = 1;

   localparam int DEF_SYNC_STAGES     = 2;
   localparam int DEF_DEBOUNCE_CYCLES = 4;

   // Counter width is max(1, clog2(n)); it only has to reach n-1.
   function automatic int dbnc_cnt_w(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/full_adder.sv
// Purely combinational 1-bit full adder; sw = {Cin, B, A}, led = {carry, sum}.
module full_adder
   import basys3_pkg::*;
(
   input  logic [2:0] sw,
   output logic [1:0] led
);

   assign led[LED_SUM]  = sw[SW_A] ^ sw[SW_B] ^ sw[SW_CIN];
   assign led[LED_COUT] = (sw[SW_A] & sw[SW_B]) |
                          (sw[SW_A] & sw[SW_CIN]) |
                          (sw[SW_B] & sw[SW_CIN]);

endmodule

// File: rtl/switch_debounce.sv
// One switch bit: multi-flop synchronizer followed by a stable-count debouncer
// (or a straight pass-through when DEBOUNCE_CYCLES is 0).
module switch_debounce
   import basys3_pkg::*;
#(
   parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
   parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
)
(
   input  logic clk,
   input  logic rst,
   input  logic sw,
   output logic db
);

   logic [SYNC_STAGES-1:0] sync_p;
   logic                   s;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         sync_p <= '0;
      else
         sync_p <= {sync_p[SYNC_STAGES-2:0], sw};
   end

   assign s = sync_p[SYNC_STAGES-1];

   generate
      if (DEBOUNCE_CYCLES == 0) begin : g_bypass
         assign db = s;
      end else begin : g_dbnc
         localparam int            CW   = dbnc_cnt_w(DEBOUNCE_CYCLES);
         localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

         logic          d;
         logic [CW-1:0] cnt;

         // Any return of s to d restarts the stable-cycle count.
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               d   <= 1'b0;
               cnt <= '0;
            end else if (s == d) begin
               cnt <= '0;
            end else if (cnt == LAST) begin
               d   <= s;
               cnt <= '0;
            end else begin
               cnt <= cnt + 1'b1;
            end
         end

         assign db = d;
      end
   endgenerate

endmodule

// File: rtl/basys3_full_adder.sv
// Board-level full adder: three synchronized, debounced switches summed into
// a registered 2-bit LED result {carry, sum}.
module basys3_full_adder
   import basys3_pkg::*;
#(
   parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
   parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
)
(
   input  logic       clk,
   input  logic       rst,
   input  logic [2:0] sw,
   output logic [1:0] led
);

   logic [2:0] db;
   logic [1:0] sum_c;

   for (genvar i = 0; i < 3; i++) begin : g_sw
      switch_debounce #(
         .SYNC_STAGES     (SYNC_STAGES),
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
      ) u_db (
         .clk (clk),
         .rst (rst),
         .sw  (sw[i]),
         .db  (db[i])
      );
   end

   full_adder u_fa (
      .sw  (db),
      .led (sum_c)
   );

   // Output register stage
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         led <= 2'b00;
      else
         led <= sum_c;
   end

endmodule

// File: tb/tb_basys3_full_adder.sv
// Directed bench for basys3_full_adder: default-parameter instance plus a
// bypass (DEBOUNCE_CYCLES=0) instance, checked against a queue of expected LEDs.
module tb_basys3_full_adder;

   logic       clk = 1'b0;
   logic       rst0, rst1;
   logic [2:0] sw0, sw1;
   logic [1:0] led0, led1;

   int tests = 0;
   int fails = 0;
   logic [1:0] exp_q[$];
   logic [1:0] tt_exp [8] = '{2'b00, 2'b01, 2'b01, 2'b10, 2'b01, 2'b10, 2'b10, 2'b11};

   basys3_full_adder #(.SYNC_STAGES(2), .DEBOUNCE_CYCLES(4)) dut0 (
      .clk (clk), .rst (rst0), .sw (sw0), .led (led0)
   );

   basys3_full_adder #(.SYNC_STAGES(2), .DEBOUNCE_CYCLES(0)) dut1 (
      .clk (clk), .rst (rst1), .sw (sw1), .led (led1)
   );

   always #5 clk = ~clk;

   function automatic logic [1:0] ref_add(input logic [2:0] v);
      return {1'b0, v[0]} + {1'b0, v[1]} + {1'b0, v[2]};
   endfunction

   function automatic logic [1:0] led_of(input int which);
      return (which != 0) ? led1 : led0;
   endfunction

   task automatic check(input string tag, input logic [1:0] obs, input logic [1:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic drive(input int which, input logic [2:0] v, input logic [1:0] exp);
      if (which != 0) sw1 = v;
      else            sw0 = v;
      exp_q.push_back(exp);
   endtask

   // LED must hold prev for lat-1 edges, take the queued value at edge lat, then stay.
   task automatic expect_after(input int which, input string tag, input logic [1:0] prev,
                               input int lat, input int hold);
      logic [1:0] e;
      e = 2'b00;
      for (int i = 1; i <= hold; i++) begin
         @(posedge clk); #1;
         if (i < lat) begin
            check({tag, "_hold"}, led_of(which), prev);
         end else if (i == lat) begin
            if (exp_q.size() == 0) begin
               check({tag, "_noexp"}, 2'bxx, prev);
            end else begin
               e = exp_q.pop_front();
               check(tag, led_of(which), e);
            end
         end else begin
            check({tag, "_steady"}, led_of(which), e);
         end
      end
   endtask

   task automatic idle_check(input int which, input string tag, input logic [1:0] exp, input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk); #1;
         check(tag, led_of(which), exp);
      end
   endtask

   initial begin
      logic [1:0] cur;

      // Reset held with all switches on
      rst0 = 1'b1; rst1 = 1'b1;
      sw0 = 3'b111; sw1 = 3'b111;
      #1;
      check("rst_imm0", led0, 2'b00);
      check("rst_imm1", led1, 2'b00);
      idle_check(0, "rst_hold0", 2'b00, 3);
      idle_check(1, "rst_hold1", 2'b00, 3);
      sw0 = 3'b000; sw1 = 3'b000;
      rst0 = 1'b0; rst1 = 1'b0;
      idle_check(0, "post_rst0", 2'b00, 4);

      // Exhaustive truth table
      cur = 2'b00;
      for (int v = 0; v < 8; v++) begin
         drive(0, 3'(v), tt_exp[v]);
         expect_after(0, $sformatf("tt%0d", v), cur, 7, 10);
         cur = tt_exp[v];
      end

      // Asynchronous reset mid-run, then full re-acquisition of sw=111
      #3 rst0 = 1'b1;
      #1 check("arst_imm", led0, 2'b00);
      @(posedge clk); #1;
      check("arst_hold", led0, 2'b00);
      rst0 = 1'b0;
      exp_q.push_back(ref_add(sw0));
      expect_after(0, "arst_reacq", 2'b00, 7, 9);

      drive(0, 3'b000, 2'b00);
      expect_after(0, "to000", 2'b11, 7, 10);

      // 3-cycle pulse on A must be rejected
      sw0 = 3'b001;
      idle_check(0, "pulse_in", 2'b00, 3);
      sw0 = 3'b000;
      idle_check(0, "pulse_after", 2'b00, 12);

      // B bounces 1,0,1 then settles high
      sw0 = 3'b010;
      @(posedge clk); #1;
      sw0 = 3'b000;
      @(posedge clk); #1;
      drive(0, 3'b010, ref_add(3'b010));
      expect_after(0, "settle", 2'b00, 7, 10);

      drive(0, 3'b000, ref_add(3'b000));
      expect_after(0, "settle_back", 2'b01, 7, 10);

      // All three switches at once: no intermediate LED value
      drive(0, 3'b111, ref_add(3'b111));
      expect_after(0, "simul", 2'b00, 7, 10);

      // Bypass instance
      drive(1, 3'b011, ref_add(3'b011));
      expect_after(1, "byp", 2'b00, 3, 6);

      #3 rst1 = 1'b1;
      #1 check("byp_arst_imm", led1, 2'b00);
      @(posedge clk); #1;
      check("byp_arst_hold", led1, 2'b00);
      rst1 = 1'b0;
      exp_q.push_back(ref_add(sw1));
      expect_after(1, "byp_reacq", 2'b00, 3, 6);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
